// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, constants and digit validity helper
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  localparam bcd_digit_t BCD_ZERO      = 4'd0;

  function automatic logic bcd_digit_valid(input bcd_digit_t digit);
    return (digit <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// rtl/bcd_digit_step.sv - combinational single BCD digit increment/decrement with ripple carry/borrow
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t next_digit,
  output logic       cout
);

  // cin doubles as borrow-in when counting down; cout likewise as borrow-out
  always_comb begin
    next_digit = digit;
    cout       = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit == BCD_MAX_DIGIT) begin
          next_digit = BCD_ZERO;
          cout       = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_ZERO) begin
          next_digit = BCD_MAX_DIGIT;
          cout       = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit BCD up/down counter with load, modulo limit and cascade tc
// Define BCD_COUNTER_SATURATE_EN to make terminal steps saturate instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    stepped;
  logic [DIGITS:0] carry;
  logic            carry_unused;
  logic            at_limit;
  logic            at_zero;
  logic            over_limit;
  logic            load_digits_ok;
  logic            load_ok;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (count[4*i +: 4]),
      .up         (up),
      .cin        (carry[i]),
      .next_digit (stepped[4*i +: 4]),
      .cout       (carry[i+1])
    );
  end

  // Terminal cases are caught by the comparators, so the final ripple-out is not needed.
  assign carry_unused = carry[DIGITS];

  // With valid BCD on both sides a plain binary compare orders values decimally.
  assign at_limit   = (count == limit);
  assign at_zero    = (count == '0);
  assign over_limit = (count > limit);

  always_comb begin
    load_digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(load_val[4*i +: 4])) begin
        load_digits_ok = 1'b0;
      end
    end
  end

  assign load_ok = load_digits_ok && (load_val <= limit);

  assign tc = en & ((up & at_limit) | (~up & at_zero));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          count <= load_val;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en) begin
        if (over_limit) begin
          count <= '0;
          wrap  <= 1'b1;
        end else if (up && at_limit) begin
`ifdef BCD_COUNTER_SATURATE_EN
          count <= limit;
`else
          count <= '0;
          wrap  <= 1'b1;
`endif
        end else if (!up && at_zero) begin
`ifdef BCD_COUNTER_SATURATE_EN
          count <= '0;
`else
          count <= limit;
          wrap  <= 1'b1;
`endif
        end else begin
          count <= stepped;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - directed self-checking bench for bcd_updown_counter
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, up, load;
  logic [7:0] load_val, limit;
  logic [7:0] count;
  logic       tc, wrap, load_err;

  logic       c_en;
  logic [3:0] c_lo, c_hi;
  logic       c_tc0, c_tc1, c_w0, c_w1, c_e0, c_e1;
  logic [7:0] s_count;
  logic       s_tc, s_wrap, s_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .count(count), .tc(tc),
    .wrap(wrap), .load_err(load_err)
  );

  bcd_updown_counter #(.DIGITS(1)) u_c0 (
    .clk(clk), .reset_n(reset_n), .en(c_en), .up(1'b1), .load(1'b0),
    .load_val(4'h0), .limit(4'h9), .count(c_lo), .tc(c_tc0),
    .wrap(c_w0), .load_err(c_e0)
  );

  bcd_updown_counter #(.DIGITS(1)) u_c1 (
    .clk(clk), .reset_n(reset_n), .en(c_tc0), .up(1'b1), .load(1'b0),
    .load_val(4'h0), .limit(4'h9), .count(c_hi), .tc(c_tc1),
    .wrap(c_w1), .load_err(c_e1)
  );

  bcd_updown_counter #(.DIGITS(2)) u_single (
    .clk(clk), .reset_n(reset_n), .en(c_en), .up(1'b1), .load(1'b0),
    .load_val(8'h00), .limit(8'h99), .count(s_count), .tc(s_tc),
    .wrap(s_wrap), .load_err(s_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    reset_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0;
    load_val = 8'h00; limit = 8'h99; c_en = 1'b0;
    step();
    check("reset_count", count, 8'h00);
    check("reset_wrap", wrap, 1'b0);
    check("reset_err", load_err, 1'b0);
    reset_n = 1'b1;

    // reset in the middle of counting
    load = 1'b1; load_val = 8'h47;
    step();
    check("load_47", count, 8'h47);
    load = 1'b0; reset_n = 1'b0; en = 1'b1;
    step();
    check("midreset_count", count, 8'h00);
    check("midreset_wrap", wrap, 1'b0);
    check("midreset_err", load_err, 1'b0);
    reset_n = 1'b1;

    // modulo-60 up count
    limit = 8'h59; up = 1'b1; en = 1'b1;
    check("m60_tc_low", tc, 1'b0);
    for (int i = 1; i <= 59; i++) begin
      step();
      check("m60_count", count, to_bcd(i));
    end
    check("m60_tc_high", tc, 1'b1);
    step();
`ifdef BCD_COUNTER_SATURATE_EN
    check("m60_sat_count", count, 8'h59);
    check("m60_sat_wrap", wrap, 1'b0);
`else
    check("m60_wrap_count", count, 8'h00);
    check("m60_wrap", wrap, 1'b1);
`endif
    en = 1'b0;
    #1;
    check("tc_en_off", tc, 1'b0);
    step();
    check("hold_wrap_low", wrap, 1'b0);

    // decrement with borrow
    limit = 8'h99; up = 1'b0; load = 1'b1; load_val = 8'h10;
    step();
    check("load_10", count, 8'h10);
    check("load_no_wrap", wrap, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      step();
      check("down_count", count, to_bcd(i));
    end
    check("down_tc", tc, 1'b1);
    step();
`ifdef BCD_COUNTER_SATURATE_EN
    check("down_sat_count", count, 8'h00);
    check("down_sat_wrap", wrap, 1'b0);
`else
    check("down_wrap_count", count, 8'h99);
    check("down_wrap", wrap, 1'b1);
`endif
    en = 1'b0;

    // load validation
    limit = 8'h59; load = 1'b1; load_val = 8'h25;
    step();
    check("load_25", count, 8'h25);
    load_val = 8'h3A;
    step();
    check("bad_digit_err", load_err, 1'b1);
    check("bad_digit_hold", count, 8'h25);
    load = 1'b0;
    step();
    check("err_pulse_end", load_err, 1'b0);
    load = 1'b1; load_val = 8'h75;
    step();
    check("over_limit_err", load_err, 1'b1);
    check("over_limit_hold", count, 8'h25);
    load_val = 8'h59;
    step();
    check("load_at_limit", count, 8'h59);
    check("load_at_limit_err", load_err, 1'b0);
    load_val = 8'h33; en = 1'b1; up = 1'b1;
    step();
    check("load_wins", count, 8'h33);
    check("load_wins_wrap", wrap, 1'b0);
    load = 1'b0; en = 1'b0;

    // limit drop below count, both directions
    limit = 8'h99; load = 1'b1; load_val = 8'h45;
    step();
    load = 1'b0; limit = 8'h23; en = 1'b1; up = 1'b1;
    step();
    check("drop_up_count", count, 8'h00);
    check("drop_up_wrap", wrap, 1'b1);
    en = 1'b0; limit = 8'h99; load = 1'b1;
    step();
    load = 1'b0; limit = 8'h23; en = 1'b1; up = 1'b0;
    step();
    check("drop_dn_count", count, 8'h00);
    check("drop_dn_wrap", wrap, 1'b1);
    en = 1'b0;
    step();
    check("drop_wrap_end", wrap, 1'b0);

    // cascade of two single digits against one two-digit instance
    c_en = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      step();
      check("single_count", s_count, to_bcd(i));
`ifndef BCD_COUNTER_SATURATE_EN
      check("cascade_count", {c_hi, c_lo}, to_bcd(i));
`endif
    end
    check("single_tc", s_tc, 1'b1);
    step();
`ifdef BCD_COUNTER_SATURATE_EN
    check("sat99_count", s_count, 8'h99);
    check("sat99_wrap", s_wrap, 1'b0);
`else
    check("single_roll", s_count, 8'h00);
    check("single_roll_wrap", s_wrap, 1'b1);
    check("cascade_roll", {c_hi, c_lo}, 8'h00);
`endif
    c_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
